ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder for instruction/data SRAM; far end of the core's fetch and LSU AHB masters.
//  Decodes address phase, inserts WAIT_STATES, returns read data, commits byte-masked writes.
//  Flags out-of-range/misaligned/oversize with the two-cycle ERROR response.
//  Sits behind the bus arbiter/decoder; one instance per memory region.
// PARAMETERS
//  ADDR_WIDTH   32    haddr width
//  DATA_WIDTH   32    hwdata/hrdata width (fixed 32, word memory)
//  MEM_DEPTH    1024  number of 32-bit words; valid byte range 0 .. MEM_DEPTH*4-1
//  WAIT_STATES  0     hreadyout-low cycles inserted per OKAY data phase (0..15)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   async active-low reset
//  hsel_i       in   1   slave select from decoder
//  htrans_i     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  haddr_i      in   ADDR_WIDTH  byte address (address phase)
//  hwrite_i     in   1   1=write
//  hsize_i      in   3   000 byte, 001 half, 010 word
//  hburst_i     in   3   ignored (SINGLE assumed)
//  hprot_i      in   4   ignored
//  hmastlock_i  in   1   ignored
//  hwdata_i     in   32  write data (data phase)
//  hready_i     in   1   bus-level HREADY (previous transfer complete)
//  hreadyout_o  out  1   this slave ready
//  hresp_o      out  1   0 OKAY, 1 ERROR
//  hrdata_o     out  32  read data
// BEHAVIOUR
//  - Reset: hreadyout_o=1, hresp_o=0, hrdata_o=0, state IDLE, wait cnt 0; mem contents not reset.
//  - Accept: hsel_i & hready_i & htrans_i[1] -> latch addr/write/size into addr phase regs.
//    IDLE/BUSY or !hsel_i with hready_i -> no transfer, zero-wait OKAY (hreadyout_o=1, hresp_o=0).
//  - Error check at accept: haddr>=MEM_DEPTH*4, hsize>2, or haddr not size-aligned -> ERR path.
//  - States: IDLE, WAIT, DATA, ERR1, ERR2.
//    IDLE: accept&ok -> WAIT_STATES?WAIT:DATA; accept&bad -> ERR1.
//    WAIT: hreadyout_o=0, cnt--; cnt==1 -> DATA.
//    DATA: hreadyout_o=1, hresp_o=0; completes transfer; new accept -> WAIT/DATA/ERR1, else IDLE.
//    ERR1: hreadyout_o=0, hresp_o=1 -> ERR2.
//    ERR2: hreadyout_o=1, hresp_o=1; accept in this cycle handled like DATA (pipelined).
//  - Read: hrdata_o = mem[addr_r[..:2]] (full word, lane select is master's job) only in DATA of a
//    read; 0 in all other cycles incl. WAIT/ERR. Latency = 1 + WAIT_STATES cycles after accept.
//  - Write: hwdata_i sampled on DATA cycle edge; byte strobes from size_r/addr_r[1:0]:
//    byte->1 lane, half->lanes {1:0} or {3:2}, word->all 4. ERROR transfers never write.
//  - Back-to-back write then read same addr: read DATA cycle sees new value (write committed before).
//  - Pipelined accept during DATA/ERR2 uses the new address phase; no bubble when WAIT_STATES=0.
//  - Reset mid-WAIT/ERR: transfer abandoned, no write, outputs return to reset values.
// TESTING
//  - WAIT_STATES=0, mem[4]=32'hDEADBEEF, NONSEQ read haddr 0x10 -> next cycle hreadyout=1, hrdata=DEADBEEF, hresp=0.
//  - WAIT_STATES=2, read 0x10 -> hreadyout 0,0,1 over 3 cycles; hrdata=DEADBEEF only on 3rd.
//  - Byte write 0xAB to 0x11 over word 0x11223344 then word read -> 0x1122AB44.
//  - Read haddr=MEM_DEPTH*4 (or half at 0x3) -> cycle1 hreadyout=0 hresp=1, cycle2 hreadyout=1 hresp=1, mem unchanged.
//  - Back-to-back NONSEQ write 0x5A5A5A5A @0x20 then read 0x20, WAIT_STATES=0 -> read returns 5A5A5A5A, no stall.
//  - WAIT_STATES=3, assert rst_n=0 during WAIT of a write -> hreadyout=1, hresp=0, target word unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: one memory region behind the bus decoder.
// Accepts single transfers, optionally stretches the data phase with wait
// states, answers bad addresses/sizes with the two-cycle ERROR response and
// commits byte-masked writes at the end of the OKAY data phase.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel_i,
    input  logic [1:0]            htrans_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One past the last valid byte address, one bit wider so it never wraps.
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [IDX_W+1:0]      addr_r;
    logic                  write_r;
    logic [1:0]            size_r;
    logic                  accept, bad, start;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Burst, protection and lock carry no meaning for a plain SRAM.
    logic unused_ok;
    assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

    assign accept = hsel_i & hready_i & htrans_i[1];
    assign bad    = ({1'b0, haddr_i} >= LIMIT) || (hsize_i > 3'd2) ||
                    ((hsize_i == 3'd1) && haddr_i[0]) ||
                    ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));

    // Next-state and response outputs; start marks cycles that may take a new address phase.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        hrdata_o    = '0;
        start       = 1'b0;
        case (state)
            S_IDLE: start = 1'b1;
            S_WAIT: begin
                hreadyout_o = 1'b0;
                cnt_nxt     = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!write_r) hrdata_o = mem[addr_r[IDX_W+1:2]];
                start = 1'b1;
            end
            S_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                state_nxt   = S_ERR2;
            end
            S_ERR2: begin
                hresp_o = 1'b1;
                start   = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (start) begin
            if (!accept)                state_nxt = S_IDLE;
            else if (bad)               state_nxt = S_ERR1;
            else if (WAIT_STATES != 0) begin
                state_nxt = S_WAIT;
                cnt_nxt   = 4'(WAIT_STATES);
            end else                    state_nxt = S_DATA;
        end
    end

    // State, wait counter and address-phase capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_r  <= '0;
            write_r <= 1'b0;
            size_r  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start && accept) begin
                addr_r  <= haddr_i[IDX_W+1:0];
                write_r <= hwrite_i;
                size_r  <= hsize_i[1:0];
            end
        end
    end

    // Byte lanes touched by the captured size/offset.
    always_comb begin
        case (size_r)
            2'd0:    strb = 4'b0001 << addr_r[1:0];
            2'd1:    strb = addr_r[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // Write commits on the edge closing the OKAY data phase; error paths never reach DATA.
    always_ff @(posedge clk) begin
        if (state == S_DATA && write_r) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[addr_r[IDX_W+1:2]][8*b +: 8] <= hwdata_i[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) driven by a
// transfer queue and checked cycle-by-cycle against a transaction-level model.
module tb_ahb_sram_slave;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]       hsel, hwrite, hmastlock;
    logic [1:0][1:0]  htrans;
    logic [1:0][31:0] haddr, hwdata;
    logic [1:0][2:0]  hsize, hburst;
    logic [1:0][3:0]  hprot;
    logic             hreadyout [2];
    logic             hresp [2];
    logic [31:0]      hrdata [2];

    logic [31:0] mdl [2][DEPTH];
    xfer_t       q[$];
    bit          gaps;
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_sram_slave #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
            .WAIT_STATES((g == 0) ? 0 : 2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .hsel_i(hsel[g]), .htrans_i(htrans[g]), .haddr_i(haddr[g]),
            .hwrite_i(hwrite[g]), .hsize_i(hsize[g]), .hburst_i(hburst[g]),
            .hprot_i(hprot[g]), .hmastlock_i(hmastlock[g]), .hwdata_i(hwdata[g]),
            .hready_i(hreadyout[g]),
            .hreadyout_o(hreadyout[g]), .hresp_o(hresp[g]), .hrdata_o(hrdata[g])
        );
    end

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit is_bad(input xfer_t x);
        return (x.addr >= 32'(DEPTH*4)) || (x.size > 3'd2) ||
               ((x.size == 3'd1) && (x.addr % 2 != 0)) ||
               ((x.size == 3'd2) && (x.addr % 4 != 0));
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got rdy/resp/data=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle(input int d);
        hwrite[d] = 1'($urandom);
        haddr[d]  = $urandom;
        hsize[d]  = 3'($urandom_range(0, 2));
        case ($urandom_range(0, 2))
            0: begin hsel[d] = 1'b0; htrans[d] = 2'b10; end
            1: begin hsel[d] = 1'b1; htrans[d] = 2'b00; end
            default: begin hsel[d] = 1'b1; htrans[d] = 2'b01; end
        endcase
    endtask

    task automatic drive_addr(input int d, input xfer_t x);
        hsel[d]      = 1'b1;
        htrans[d]    = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        haddr[d]     = x.addr;
        hwrite[d]    = x.wr;
        hsize[d]     = x.size;
        hburst[d]    = 3'($urandom);
        hprot[d]     = 4'($urandom);
        hmastlock[d] = 1'($urandom);
    endtask

    task automatic push(input logic [31:0] a, input bit w, input logic [2:0] s, input logic [31:0] wd);
        xfer_t x;
        x.addr = a; x.wr = w; x.size = s; x.wdata = wd;
        q.push_back(x);
    endtask

    // Drain the queue through instance d; every cycle is compared with the model.
    task automatic run(input int d);
        xfer_t cur;
        bit busy = 0;
        bit last, bad;
        int ph = 0;
        int lo;
        logic [33:0] exp;
        cur.addr = '0; cur.wr = 0; cur.size = '0; cur.wdata = '0;
        while (q.size() > 0 || busy) begin
            @(negedge clk);
            last = 1;
            if (busy) begin
                bad = is_bad(cur);
                if (bad)              exp = (ph == 0) ? {2'b01, 32'h0} : {2'b11, 32'h0};
                else if (ph < ws(d))  exp = 34'h0;
                else                  exp = {2'b10, cur.wr ? 32'h0 : mdl[d][cur.addr[7:2]]};
                last = bad ? (ph == 1) : (ph == ws(d));
                check($sformatf("dut%0d %s a=%h sz=%0d ph%0d", d, cur.wr ? "wr" : "rd",
                                cur.addr, cur.size, ph),
                      {hreadyout[d], hresp[d], hrdata[d]}, exp);
                if (last && !bad && cur.wr) begin
                    lo = int'(cur.addr % 4);
                    for (int b = 0; b < 4; b++)
                        if (b >= lo && b < lo + (1 << cur.size))
                            mdl[d][cur.addr[7:2]][8*b +: 8] = cur.wdata[8*b +: 8];
                end
                hwdata[d] = cur.wdata;
            end else begin
                check($sformatf("dut%0d idle", d), {hreadyout[d], hresp[d], hrdata[d]},
                      {2'b10, 32'h0});
            end
            if (last) begin
                if (q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    cur  = q.pop_front();
                    drive_addr(d, cur);
                    busy = 1;
                    ph   = 0;
                end else begin
                    drive_idle(d);
                    busy = 0;
                end
            end else ph++;
        end
        @(negedge clk);
        check($sformatf("dut%0d drain", d), {hreadyout[d], hresp[d], hrdata[d]}, {2'b10, 32'h0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            hwdata[d] = '0; hburst[d] = '0; hprot[d] = '0; hmastlock[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("dut%0d reset", d), {hreadyout[d], hresp[d], hrdata[d]}, {2'b10, 32'h0});
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            gaps = 1;
            for (int i = 0; i < DEPTH; i++) push(32'(i*4), 1, 3'd2, $urandom);
            run(d);

            gaps = 0;
            push(32'h10, 1, 3'd2, 32'hDEADBEEF);
            push(32'h10, 0, 3'd2, 32'h0);
            push(32'h10, 1, 3'd2, 32'h11223344);
            push(32'h11, 1, 3'd0, 32'h0000AB00);
            push(32'h10, 0, 3'd2, 32'h0);
            push(32'(DEPTH*4), 0, 3'd2, 32'h0);
            push(32'h3, 0, 3'd1, 32'h0);
            push(32'h21, 1, 3'd2, 32'hFFFFFFFF);
            push(32'h20, 1, 3'd3, 32'hFFFFFFFF);
            push(32'hFFFFFFFC, 1, 3'd2, 32'hFFFFFFFF);
            push(32'h20, 0, 3'd2, 32'h0);
            push(32'h20, 1, 3'd2, 32'h5A5A5A5A);
            push(32'h20, 0, 3'd2, 32'h0);
            push(32'h22, 1, 3'd1, 32'hC3C30000);
            push(32'h20, 0, 3'd2, 32'h0);
            run(d);

            gaps = 1;
            for (int i = 0; i < 150; i++) begin
                logic [31:0] a;
                logic [2:0]  s;
                a = ($urandom_range(0, 9) == 0) ? 32'(DEPTH*4) + 32'($urandom_range(0, 64))
                                                : 32'($urandom_range(0, DEPTH*4-1));
                s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                push(a, 1'($urandom), s, $urandom);
            end
            run(d);
        end

        // Reset during the wait states of a write on the 2-wait instance.
        @(negedge clk);
        begin
            xfer_t x;
            x.addr = 32'h30; x.wr = 1; x.size = 3'd2; x.wdata = 32'hCAFEF00D;
            drive_addr(1, x);
            @(negedge clk);
            hwdata[1] = x.wdata;
            check("dut1 wait before reset", {hreadyout[1], hresp[1], hrdata[1]}, 34'h0);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("dut1 reset mid-wait", {hreadyout[1], hresp[1], hrdata[1]}, {2'b10, 32'h0});
            @(negedge clk);
            drive_idle(1);
            rst_n = 1'b1;
        end
        gaps = 0;
        push(32'h30, 0, 3'd2, 32'h0);
        run(1);
        push(32'h10, 0, 3'd2, 32'h0);
        run(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
